// File: rtl/minimization_sweep_ctrl.sv
// minimization_sweep_ctrl: steps codes FIRST..LAST through a combinational unit and
// streams one sampled result/mismatch record per code on a valid/ready interface.
module minimization_sweep_ctrl #(
    parameter int CODE_W = 4,
    parameter int OUT_W  = 3,
    parameter int FIRST  = 0,
    parameter int LAST   = 9,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              abort,
    output logic [CODE_W-1:0] code_o,
    input  logic [OUT_W-1:0]  res_i,
    input  logic [OUT_W-1:0]  exp_i,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CODE_W-1:0] rec_code,
    output logic [OUT_W-1:0]  rec_res,
    output logic              rec_mis,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CODE_W-1:0] FIRST_C = CODE_W'(FIRST);
    localparam logic [CODE_W-1:0] LAST_C = CODE_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mis;

    assign mis = res_i != exp_i;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            code_o    <= FIRST_C;
            rec_valid <= 1'b0;
            rec_code  <= '0;
            rec_res   <= '0;
            rec_mis   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
        end else if (state != IDLE && abort) begin
            // abort outranks any handshake or capture in flight
            state     <= IDLE;
            rec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state   <= WAIT;
                    code_o  <= FIRST_C;
                    err_cnt <= '0;
                    cnt     <= CNT_INIT;
                    busy    <= 1'b1;
                end
                WAIT: if (cnt == '0) begin
                    state     <= HOLD;
                    rec_valid <= 1'b1;
                    rec_code  <= code_o;
                    rec_res   <= res_i;
                    rec_mis   <= mis;
                    err_cnt   <= (mis && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HOLD: if (rec_ready) begin
                    rec_valid <= 1'b0;
                    if (code_o != LAST_C) begin
                        state  <= WAIT;
                        code_o <= code_o + 1'b1;
                        cnt    <= CNT_INIT;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_minimization_sweep_ctrl.sv
// tb_minimization_sweep_ctrl: randomized sweeps of minimization_sweep_ctrl checked
// against an expected record list derived from the sweep rules.
module tb_minimization_sweep_ctrl;
    localparam int FIRST = 0;
    localparam int LAST = 9;
    localparam int ERR_W = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       code_o;
    logic [2:0]       res_i;
    logic [2:0]       exp_i;
    logic             rec_valid;
    logic             rec_ready = 1'b1;
    logic [3:0]       rec_code;
    logic [2:0]       rec_res;
    logic             rec_mis;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       xor_tab [16];
    int               total = 0;
    int               passed = 0;

    minimization_sweep_ctrl #(.FIRST(FIRST), .LAST(LAST), .SETTLE(1), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .code_o(code_o),
        .res_i(res_i), .exp_i(exp_i), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_code(rec_code), .rec_res(rec_res), .rec_mis(rec_mis), .busy(busy),
        .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] unit_f(input logic [3:0] c);
        return {c[1] ^ c[0], ~(c[1] ^ c[0]), c[0]};
    endfunction

    function automatic int sat(input int n);
        return n > ERR_MAX ? ERR_MAX : n;
    endfunction

    assign res_i = unit_f(code_o);
    assign exp_i = res_i ^ xor_tab[code_o];

    task automatic set_tab(input logic [2:0] v);
        for (int i = 0; i < 16; i++) xor_tab[i] = v;
    endtask

    // One full sweep; every handshake is compared against the next expected record.
    task automatic run_sweep(input string nm, input int ready_pct, input bit chk_gap,
                             input int stall_code, input int restart_at);
        int exp_code, nrec, nmis, ndone, last_cyc, nstall, nc;
        bit stall, nxt;
        logic [3:0] pc;
        logic [2:0] pr;
        logic pm;
        exp_code = FIRST; nrec = 0; nmis = 0; ndone = 0; last_cyc = -1; nstall = 0;
        stall = 0; nxt = 0; nc = 0; pc = '0; pr = '0; pm = 0;
        @(negedge clk); start = 1'b1; rec_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (busy !== 1'b1 || err_cnt !== '0 || code_o !== 4'(FIRST))
            $display("FAIL %s start: busy=%b err=%0d code=%0d, need busy=1 err=0 code=%0d",
                     nm, busy, err_cnt, code_o, FIRST);
        else passed++;
        for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = (cyc == restart_at);
            if (stall) begin
                total++;
                if (!(rec_valid === 1'b1 && rec_code === pc && rec_res === pr && rec_mis === pm && code_o === pc))
                    $display("FAIL %s stall: valid=%b code=%0d res=%b mis=%b code_o=%0d, need 1 %0d %b %b %0d",
                             nm, rec_valid, rec_code, rec_res, rec_mis, code_o, pc, pr, pm, pc);
                else passed++;
            end
            if (nxt) begin
                nxt = 0;
                total++;
                if (code_o !== 4'(nc)) $display("FAIL %s advance: code_o=%0d need %0d", nm, code_o, nc);
                else passed++;
            end
            if (done) begin
                ndone++;
                total++;
                if (nrec != LAST - FIRST + 1 || err_cnt !== ERR_W'(sat(nmis)) || busy !== 1'b1)
                    $display("FAIL %s done: recs=%0d err=%0d busy=%b, need recs=%0d err=%0d busy=1",
                             nm, nrec, err_cnt, busy, LAST - FIRST + 1, sat(nmis));
                else passed++;
            end
            if (rec_valid && rec_code == 4'(stall_code) && nstall < 5) begin
                rec_ready = 1'b0;
                nstall++;
            end else rec_ready = $urandom_range(0, 99) < 32'(ready_pct);
            stall = rec_valid && !rec_ready;
            pc = rec_code; pr = rec_res; pm = rec_mis;
            if (rec_valid && rec_ready) begin
                nmis += (xor_tab[exp_code] != 3'b0) ? 1 : 0;
                total++;
                if (rec_code !== 4'(exp_code) || rec_res !== unit_f(4'(exp_code)) ||
                    rec_mis !== (xor_tab[exp_code] != 3'b0) || err_cnt !== ERR_W'(sat(nmis)) ||
                    code_o !== rec_code)
                    $display("FAIL %s record: code=%0d res=%b mis=%b err=%0d code_o=%0d, need %0d %b %b %0d %0d",
                             nm, rec_code, rec_res, rec_mis, err_cnt, code_o, exp_code,
                             unit_f(4'(exp_code)), xor_tab[exp_code] != 3'b0, sat(nmis), exp_code);
                else passed++;
                if (chk_gap && last_cyc >= 0) begin
                    total++;
                    if (cyc - last_cyc != 2) $display("FAIL %s gap: %0d cycles need 2", nm, cyc - last_cyc);
                    else passed++;
                end
                last_cyc = cyc;
                if (exp_code != LAST) begin nxt = 1; nc = exp_code + 1; end
                nrec++;
                exp_code++;
            end
        end
        start = 1'b0;
        rec_ready = 1'b1;
        total++;
        if (ndone != 1) $display("FAIL %s timeout: done seen %0d times need 1", nm, ndone);
        else passed++;
        if (stall_code >= 0) begin
            total++;
            if (nstall != 5) $display("FAIL %s stall_len: %0d cycles need 5", nm, nstall);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || code_o !== 4'(LAST))
            $display("FAIL %s end: busy=%b done=%b code=%0d, need 0 0 %0d", nm, busy, done, code_o, LAST);
        else passed++;
    endtask

    task automatic test_reset();
        set_tab(3'b0);
        rst_b = 1'b0;
        #3;
        total++;
        if (code_o !== 4'(FIRST) || rec_valid !== 0 || rec_code !== 0 || rec_res !== 0 ||
            rec_mis !== 0 || busy !== 0 || done !== 0 || err_cnt !== 0)
            $display("FAIL reset: code=%0d valid=%b rcode=%0d res=%b mis=%b busy=%b done=%b err=%0d, need all 0",
                     code_o, rec_valid, rec_code, rec_res, rec_mis, busy, done, err_cnt);
        else passed++;
        @(negedge clk); rst_b = 1'b1;
    endtask

    task automatic test_basic();
        set_tab(3'b0);
        run_sweep("basic", 100, 1, -1, -1);
        set_tab(3'b0); xor_tab[5] = 3'b111;
        run_sweep("mis5", 100, 1, -1, -1);
    endtask

    task automatic test_stall();
        set_tab(3'b0);
        run_sweep("stall", 100, 0, 3, -1);
    endtask

    task automatic test_abort();
        bit found;
        bit bad;
        set_tab(3'b0); xor_tab[1] = 3'b010; xor_tab[3] = 3'b001;
        found = 0; bad = 0;
        @(negedge clk); start = 1'b1; rec_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (rec_valid && rec_code == 4'd6) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) $display("FAIL abort_reach: code 6 record not seen");
        else passed++;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++;
        if (busy !== 0 || rec_valid !== 0 || done !== 0 || err_cnt !== ERR_W'(2) || code_o !== 4'd6)
            $display("FAIL abort: busy=%b valid=%b done=%b err=%0d code=%0d, need 0 0 0 2 6",
                     busy, rec_valid, done, err_cnt, code_o);
        else passed++;
        repeat (6) begin
            @(negedge clk);
            if (rec_valid || done || busy) bad = 1;
        end
        total++;
        if (bad) $display("FAIL abort_quiet: activity after abort, need none");
        else passed++;
        set_tab(3'b0);
        run_sweep("restart", 100, 1, -1, -1);
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL start_abort_idle: busy=%b need 0", busy);
        else passed++;
    endtask

    task automatic test_saturate();
        set_tab(3'b111);
        run_sweep("saturate", 100, 1, -1, -1);
    endtask

    task automatic test_reset_mid();
        bit found;
        set_tab(3'b0); xor_tab[1] = 3'b100;
        found = 0;
        @(negedge clk); start = 1'b1; rec_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (busy && !rec_valid && code_o == 4'd4) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) $display("FAIL rst_mid_reach: WAIT on code 4 not seen");
        else passed++;
        #2 rst_b = 1'b0;
        #1;
        total++;
        if (code_o !== 4'(FIRST) || rec_valid !== 0 || rec_code !== 0 || rec_res !== 0 ||
            rec_mis !== 0 || busy !== 0 || done !== 0 || err_cnt !== 0)
            $display("FAIL rst_mid: code=%0d valid=%b rcode=%0d res=%b mis=%b busy=%b done=%b err=%0d, need all 0",
                     code_o, rec_valid, rec_code, rec_res, rec_mis, busy, done, err_cnt);
        else passed++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_hold: busy=%b need 0", busy);
        else passed++;
        rst_b = 1'b1;
        run_sweep("start_busy", 100, 1, -1, 4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++)
                xor_tab[i] = ($urandom_range(0, 99) < 30) ? 3'($urandom_range(1, 7)) : 3'b0;
            run_sweep("random", int'($urandom_range(30, 100)), 0, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
